// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural register indices and NZCV flag layout.
package cpu_pkg;

  localparam int unsigned XzrIdx = 31;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Field order matches the bit positions above (n is the MSB).
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic flags_t make_flags(logic n, logic z, logic c, logic v);
    flags_t f;
    f.n = n;
    f.z = z;
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/zero_detect.sv
// Wide zero detector: first level of 4-input NORs, then a tree of 4-input ANDs.
module zero_detect #(
  parameter int unsigned BITS = 64
) (
  input  logic [BITS-1:0] data_i,
  output logic            zero_o
);

  localparam int unsigned Groups = (BITS + 3) / 4;

  function automatic int unsigned clog4(int unsigned n);
    int unsigned lvl;
    int unsigned span;
    lvl  = 0;
    span = 1;
    while (span < n) begin
      span = span * 4;
      lvl  = lvl + 1;
    end
    return lvl;
  endfunction

  localparam int unsigned Levels = clog4(Groups);

  // Level l occupies node[l*Groups +: Groups]; out-of-range tree inputs are padded with 1.
  logic [(Levels+1)*Groups-1:0] node;

  for (genvar g = 0; g < Groups; g++) begin : g_nor
    logic [3:0] quad;
    for (genvar k = 0; k < 4; k++) begin : g_in
      if (4 * g + k < BITS) begin : g_real
        assign quad[k] = data_i[4*g+k];
      end else begin : g_pad
        assign quad[k] = 1'b0;
      end
    end
    assign node[g] = ~|quad;
  end

  for (genvar l = 0; l < Levels; l++) begin : g_lvl
    for (genvar g = 0; g < Groups; g++) begin : g_and
      logic [3:0] quad;
      for (genvar k = 0; k < 4; k++) begin : g_in
        if (4 * g + k < Groups) begin : g_real
          assign quad[k] = node[l*Groups+4*g+k];
        end else begin : g_pad
          assign quad[k] = 1'b1;
        end
      end
      assign node[(l+1)*Groups+g] = &quad;
    end
  end

  // Top-level entries other than index 0 are constant 1, so this reduces to node[Levels*Groups].
  assign zero_o = &node[Levels*Groups +: Groups];

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with NZCV flag register and forwarding request.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned BITS = 64,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [BITS-1:0] alu_result,
  input  logic            alu_carry,
  input  logic            alu_overflow,
  input  logic            set_flags,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [REGW-1:0] dest_reg,
  input  logic [BITS-1:0] store_data,
  output logic            out_valid,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [BITS-1:0] out_result,
  output logic [BITS-1:0] out_store_data,
  output logic [REGW-1:0] out_dest_reg,
  output logic [3:0]      flags,
  output logic            zero_now,
  output logic            fwd_en,
  output logic [REGW-1:0] fwd_reg
);

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [BITS-1:0] result_q, result_d;
  logic [BITS-1:0] store_data_q, store_data_d;
  logic [REGW-1:0] dest_reg_q, dest_reg_d;
  flags_t          flags_q, flags_d;
  logic            dest_is_xzr;

  zero_detect #(
    .BITS(BITS)
  ) u_zero_detect (
    .data_i(alu_result),
    .zero_o(zero_now)
  );

  assign dest_is_xzr = (dest_reg == REGW'(XzrIdx));

  // Each register is a hold/load 2:1 mux in front of a plain D flop; reset wins in the flop.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    dest_reg_d   = dest_reg_q;
    flags_d      = flags_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!stall) begin
      valid_d      = in_valid;
      reg_write_d  = reg_write & in_valid & ~dest_is_xzr;
      mem_read_d   = mem_read & in_valid;
      mem_write_d  = mem_write & in_valid;
      result_d     = alu_result;
      store_data_d = store_data;
      dest_reg_d   = dest_reg;
      if (in_valid && set_flags) begin
        flags_d = make_flags(alu_result[BITS-1], zero_now, alu_carry, alu_overflow);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      result_q     <= '0;
      store_data_q <= '0;
      dest_reg_q   <= '0;
      flags_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      dest_reg_q   <= dest_reg_d;
      flags_q      <= flags_d;
    end
  end

  always_comb begin
    out_valid      = valid_q;
    out_reg_write  = reg_write_q;
    out_mem_read   = mem_read_q;
    out_mem_write  = mem_write_q;
    out_result     = result_q;
    out_store_data = store_data_q;
    out_dest_reg   = dest_reg_q;
    flags          = flags_q;
    // Loads are never forwarded; the reset term keeps stale state from forwarding while in reset.
    fwd_en         = ~reset & valid_q & reg_write_q & ~mem_read_q;
    fwd_reg        = dest_reg_q;
  end

endmodule
